// File: rtl/acc_dispatch.sv
// Accelerator dispatcher: decodes one instruction per job, enables a single
// accelerator channel and reports completion, abort or a coded error.
module acc_dispatch #(
  parameter int             NUM_ACC = 4,
  parameter int             SEL_W   = 3,
  parameter logic [5:0]     PREFIX  = 6'b111111,
  parameter int             TIMEOUT = 1024,
  parameter int             TO_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instruction,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               abort,
  input  logic [NUM_ACC-1:0] read_done,
  input  logic [NUM_ACC-1:0] write_done,
  output logic [NUM_ACC-1:0] acc_enable,
  output logic               acc_done,
  output logic               acc_err,
  output logic [1:0]         err_code,
  output logic               busy,
  output logic [SEL_W-1:0]   active_id
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_BAD   = 2'b01;
  localparam logic [1:0] CODE_PROTO = 2'b10;
  localparam logic [1:0] CODE_TMO   = 2'b11;

  state_t             state, state_n;
  logic [TO_W-1:0]    cnt, cnt_n;
  logic [SEL_W-1:0]   id_n;
  logic [1:0]         code_n;
  logic               done_n, err_n, busy_n;
  logic [NUM_ACC-1:0] en_n;

  logic [SEL_W-1:0]   instr_id;
  logic               instr_ok;
  logic               act_rd, act_wr, timeout_hit;

  // Channel ids are 1-based; id 0 never maps to a channel.
  function automatic logic [NUM_ACC-1:0] onehot(input logic [SEL_W-1:0] id);
    logic [NUM_ACC-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_ACC; i++)
      v[i] = (id == SEL_W'(i + 1));
    return v;
  endfunction

  function automatic logic sel_flag(input logic [NUM_ACC-1:0] flags,
                                    input logic [SEL_W-1:0]   id);
    return |(flags & onehot(id));
  endfunction

  assign instr_id    = instruction[SEL_W-1:0];
  assign instr_ok    = (instruction[31:26] == PREFIX) &&
                       (instruction[25:SEL_W] == '0) &&
                       (instr_id != '0) &&
                       (32'(instr_id) <= 32'(NUM_ACC));
  assign act_rd      = sel_flag(read_done, active_id);
  assign act_wr      = sel_flag(write_done, active_id);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_W'(TIMEOUT - 1));
  assign instr_ready = (state == IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    id_n    = active_id;
    code_n  = err_code;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          if (instr_ok) begin
            id_n    = instr_id;
            cnt_n   = '0;
            code_n  = CODE_NONE;
            state_n = RUN;
          end else begin
            code_n  = CODE_BAD;
            err_n   = 1'b1;
            state_n = ERROR;
          end
        end
      end
      RUN: begin
        if (act_rd && act_wr) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else if (abort) begin
          state_n = IDLE;
        end else if (act_wr) begin
          code_n  = CODE_PROTO;
          err_n   = 1'b1;
          state_n = ERROR;
        end else if (timeout_hit) begin
          code_n  = CODE_TMO;
          err_n   = 1'b1;
          state_n = ERROR;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      ERROR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN);
    en_n   = busy_n ? onehot(id_n) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      active_id  <= '0;
      err_code   <= CODE_NONE;
      acc_done   <= 1'b0;
      acc_err    <= 1'b0;
      busy       <= 1'b0;
      acc_enable <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      active_id  <= id_n;
      err_code   <= code_n;
      acc_done   <= done_n;
      acc_err    <= err_n;
      busy       <= busy_n;
      acc_enable <= en_n;
    end
  end

endmodule

// File: tb/tb_acc_dispatch.sv
// Scoreboard bench for acc_dispatch: expected completion/error pulses are
// queued at issue time and checked by an independent pulse monitor.
module tb_acc_dispatch;

  localparam int NUM_ACC = 4;
  localparam int SEL_W   = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        instruction;
  logic               instr_valid;
  logic               instr_ready;
  logic               abort;
  logic [NUM_ACC-1:0] read_done;
  logic [NUM_ACC-1:0] write_done;
  logic [NUM_ACC-1:0] acc_enable;
  logic               acc_done;
  logic               acc_err;
  logic [1:0]         err_code;
  logic               busy;
  logic [SEL_W-1:0]   active_id;

  int n_tests = 0;
  int n_fail  = 0;

  // {done, err, err_code[1:0], active_id[2:0]}
  logic [6:0] exp_q[$];

  acc_dispatch #(
    .NUM_ACC(NUM_ACC), .SEL_W(SEL_W), .PREFIX(6'b111111),
    .TIMEOUT(8), .TO_W(16)
  ) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .abort(abort),
    .read_done(read_done), .write_done(write_done), .acc_enable(acc_enable),
    .acc_done(acc_done), .acc_err(acc_err), .err_code(err_code),
    .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents the instruction for exactly one edge (dispatcher must be idle).
  task automatic send(input logic [31:0] instr);
    instruction = instr;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instruction = '0;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && (acc_done === 1'b1 || acc_err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {25'd0, acc_done, acc_err, err_code, active_id}, 32'd0);
      end else begin
        check("pulse", {25'd0, acc_done, acc_err, err_code, active_id},
              {25'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    reset = 1'b0; instruction = '0; instr_valid = 1'b0; abort = 1'b0;
    read_done = '0; write_done = '0;
    tick(); tick();
    check("rst_enable", 32'(acc_enable), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err_code", 32'(err_code), 32'h0);
    check("rst_active_id", 32'(active_id), 32'h0);
    check("rst_ready", 32'(instr_ready), 32'h1);
    reset = 1'b1;
    tick();

    // Normal job on channel 2
    exp_q.push_back({1'b1, 1'b0, 2'b00, 3'd2});
    send(32'hFC000002);
    check("t1_enable", 32'(acc_enable), 32'h2);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_ready", 32'(instr_ready), 32'h0);
    tick();
    read_done = 4'b0010;
    tick(); tick();
    check("t1_rd_only_stays", 32'(acc_enable), 32'h2);
    write_done = 4'b0010;
    tick();
    read_done = '0; write_done = '0;
    check("t1_done", 32'(acc_done), 32'h1);
    check("t1_en_off", 32'(acc_enable), 32'h0);
    check("t1_ready_c", 32'(instr_ready), 32'h0);
    tick();
    check("t1_ready_c1", 32'(instr_ready), 32'h1);
    check("t1_done_one", 32'(acc_done), 32'h0);

    // Bad instructions: id 0, id beyond NUM_ACC, wrong prefix
    begin
      logic [31:0] bad [3] = '{32'hFC000000, 32'hFC000005, 32'hF8000001};
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back({1'b0, 1'b1, 2'b01, 3'd2});
        send(bad[i]);
        check("t2_err", 32'(acc_err), 32'h1);
        check("t2_en", 32'(acc_enable), 32'h0);
        check("t2_code", 32'(err_code), 32'h1);
        tick();
        check("t2_ready", 32'(instr_ready), 32'h1);
        check("t2_en2", 32'(acc_enable), 32'h0);
      end
    end

    // Watchdog on channel 1
    exp_q.push_back({1'b0, 1'b1, 2'b11, 3'd1});
    send(32'hFC000001);
    check("t3_code_cleared", 32'(err_code), 32'h0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (acc_enable[0]) cnt++;
      if (acc_err) break;
      tick();
    end
    check("t3_en_cycles", 32'(cnt), 32'd8);
    check("t3_err", 32'(acc_err), 32'h1);
    check("t3_code", 32'(err_code), 32'h3);
    tick();

    // Protocol error on channel 3, foreign flags ignored
    exp_q.push_back({1'b0, 1'b1, 2'b10, 3'd3});
    send(32'hFC000003);
    tick();
    read_done = 4'b0011; write_done = 4'b0011;
    tick(); tick();
    check("t4_enable", 32'(acc_enable), 32'h4);
    read_done = 4'b0000; write_done = 4'b0010;
    tick();
    check("t4_still_run", 32'(busy), 32'h1);
    write_done = 4'b0100;
    tick();
    read_done = '0; write_done = '0;
    check("t4_err", 32'(acc_err), 32'h1);
    check("t4_en_off", 32'(acc_enable), 32'h0);
    check("t4_code", 32'(err_code), 32'h2);
    tick();

    // Abort on channel 1: no pulse, err_code kept
    send(32'hFC000001);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_en_off", 32'(acc_enable), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_ready", 32'(instr_ready), 32'h1);
    check("t5_code_kept", 32'(err_code), 32'h0);
    tick();

    // Completion beats abort in the same cycle
    exp_q.push_back({1'b1, 1'b0, 2'b00, 3'd1});
    send(32'hFC000001);
    tick();
    read_done = 4'b0001; write_done = 4'b0001; abort = 1'b1;
    tick();
    read_done = '0; write_done = '0; abort = 1'b0;
    check("t5_done_wins", 32'(acc_done), 32'h1);
    tick();

    // Reset mid-job on channel 4
    send(32'hFC000004);
    tick();
    check("t6_enable", 32'(acc_enable), 32'h8);
    check("t6_id", 32'(active_id), 32'h4);
    read_done = 4'b1000;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    read_done = '0;
    check("t6_en", 32'(acc_enable), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_done", 32'(acc_done), 32'h0);
    check("t6_err", 32'(acc_err), 32'h0);
    check("t6_code", 32'(err_code), 32'h0);
    check("t6_id0", 32'(active_id), 32'h0);
    check("t6_ready", 32'(instr_ready), 32'h1);
    write_done = 4'b1000;
    tick(); tick();
    write_done = '0;
    check("t6_idle_ignores_flags", 32'(busy), 32'h0);
    tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_dispatch.md
# acc_dispatch

Parameterised accelerator dispatcher for the data/control router. It accepts 32-bit accelerator instructions over a valid/ready handshake and enables exactly one of `NUM_ACC` accelerator channels. It tracks each channel's read-done and write-done completion flags, then reports completion or a coded error (bad opcode, protocol violation, timeout). It sits between the instruction source and the FFT/FIR/IIR-class accelerators. It generalises fixed three-channel decoding to N channels and adds abort and watchdog behaviour.

## Interface
Parameters:
- `NUM_ACC`, 4, number of accelerator channels; must be at least 1 and at most 2^`SEL_W`−1.
- `SEL_W`, 3, width of the channel-select field `instruction[SEL_W-1:0]`.
- `PREFIX`, 6'b111111, required value of `instruction[31:26]`.
- `TIMEOUT`, 1024, maximum number of RUN cycles per job; 0 disables the watchdog.
- `TO_W`, 16, watchdog counter width; `TIMEOUT` must be less than 2^`TO_W`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `instruction`  in  32  instruction word.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  dispatcher can accept an instruction.
- `abort`  in  1  cancels the running job.
- `read_done`  in  NUM_ACC  per-channel read-complete flag.
- `write_done`  in  NUM_ACC  per-channel write-complete flag.
- `acc_enable`  out  NUM_ACC  one-hot channel enable.
- `acc_done`  out  1  one-cycle completion pulse.
- `acc_err`  out  1  one-cycle error pulse.
- `err_code`  out  2  last error: 00 none, 01 bad instruction, 10 protocol, 11 timeout.
- `busy`  out  1  high while a job is in RUN.
- `active_id`  out  SEL_W  channel id of the current or last job.

## Operation
- States: IDLE, RUN, DONE, ERROR.
- `instr_ready` is 1 only in IDLE; it is derived combinationally from state.
- An instruction is accepted on a clock edge with `instr_valid`&`instr_ready`.
- Decode rules for an accepted instruction:
  - It is valid iff `[31:26]`==`PREFIX`, `[25:SEL_W]`==0, and id=`[SEL_W-1:0]` is in 1..`NUM_ACC`.
  - Valid: load `active_id`=id, clear the watchdog counter, clear `err_code` to 00, go to RUN.
  - Invalid: go to ERROR with code 01; `active_id` is unchanged.
- RUN behaviour:
  - `acc_enable[active_id-1]`=1; all other enable bits are 0; `busy`=1.
  - Only the flags of the active channel are observed. Flags of other channels are ignored.
- RUN exit conditions, evaluated each edge in this priority order:
  1. `read_done`&`write_done` of the active channel → DONE.
  2. `abort` → IDLE, with no pulse and `err_code` unchanged.
  3. `write_done`&!`read_done` → ERROR, code 10.
  4. Watchdog: `TIMEOUT`≠0 and counter==`TIMEOUT`−1 → ERROR, code 11.
  5. Otherwise stay in RUN and increment the counter. The counter saturates and never wraps.
- `read_done` alone keeps the channel in RUN.
- DONE: `acc_done`=1 for this single cycle, all enables 0, then IDLE.
- ERROR: `acc_err`=1 for this single cycle, all enables 0, then IDLE. `err_code` holds until the next accepted valid instruction.
- `abort` outside RUN has no effect.
- Reset while `reset`=0 at an edge, whatever the current state, including mid-job:
  - State returns to IDLE and the counter clears.
  - `acc_enable`=0, `acc_done`=0, `acc_err`=0, `err_code`=00, `busy`=0, `active_id`=0.
  - `instr_ready`=1 from the first cycle after reset.

## Timing
- All outputs except `instr_ready` are registered.
- Accept at edge E:
  - `acc_enable` and `busy` are high from E+1.
  - Completion flags are first sampled at edge E+1.
- Completion sampled at edge C:
  - `acc_done` and enables low during C..C+1.
  - `instr_ready` is 1 from C+1.
  - The next instruction can be accepted at edge C+2, so there is a minimum 1-cycle gap between jobs.
- Timeout: enable stays high exactly `TIMEOUT` cycles, then `acc_err` pulses in the following cycle.
- Bad instruction accepted at E: `acc_err` is high during E..E+1, and `instr_ready` returns high after that cycle.
- Abort sampled at edge A: enables drop after A, and `instr_ready` is 1 immediately after A.
- Both flags and `abort` in the same cycle: completion wins and `acc_done` pulses.

## Test plan
- Reset, then send `instruction`=0xFC000002 (id 2) with `NUM_ACC`=4. Hold `read_done[1]`=1 at cycle 3 and `write_done[1]`=1 at cycle 5. Required: `acc_enable`=4'b0010 from E+1, one `acc_done` pulse, `active_id`=2, `err_code`=00.
- Send 0xFC000000, 0xFC000005 and 0xF8000001 in turn. Required: each gives one `acc_err` pulse with `err_code`=01, and `acc_enable` never asserts.
- Set `TIMEOUT`=8 and send id 1 with flags held low. Required: `acc_enable[0]` high exactly 8 cycles, then `acc_err` with code 11.
- Run id 3 and drive `write_done[2]`=1 with `read_done[2]`=0. Required: code 10 and the enable drops. Toggling flags on channels 1 and 2 during the run must have no effect.
- Run id 1 and assert `abort` at cycle 4. Required: enable drops with no pulses and `instr_ready`=1. A second abort in the same cycle as completion must yield `acc_done`.
- Drop `reset` to 0 mid-RUN on id 4. Required: all outputs return to their reset values next cycle, with no `acc_done`.
